// File: rtl/mem_port_arbiter_pkg.sv
// Shared region encodings, owner ids and the pending-response record for the port-A arbiter.
// No logic of its own; latency and backpressure belong to the modules that import it.
// The region of an address is always its two most significant bits.
package mem_port_arbiter_pkg;

  localparam logic [1:0] REGION_CODE   = 2'b00;
  localparam logic [1:0] REGION_RAM_LO = 2'b01;
  localparam logic [1:0] REGION_RAM_HI = 2'b10;
  localparam logic [1:0] REGION_IO     = 2'b11;

  typedef enum logic [1:0] {
    OWNER_0    = 2'd0,
    OWNER_1    = 2'd1,
    OWNER_NONE = 2'd2
  } owner_t;

  typedef struct packed {
    logic       vld;
    owner_t     owner;
    logic [1:0] region;
    logic       perr;
  } pend_t;

  // Callers zero-extend the address to 32 bits and pass its real width.
  function automatic logic [1:0] region_of(input logic [31:0] addr, input int unsigned addr_w);
    return addr[addr_w-1 -: 2];
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select: a live lock holds the port, otherwise round-robin on ties.
// Purely combinational, zero latency.
// No backpressure; an unselected requester simply sees no grant this cycle.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       rr_last,
  input  logic [1:0] lock_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = {req1, req0};
    if (lock_owner == OWNER_0 && req0) begin
      gnt = 2'b01;
    end else if (lock_owner == OWNER_1 && req1) begin
      gnt = 2'b10;
    end else if (req0 && req1) begin
      // rr_last names the previous winner, so the other one goes now.
      gnt = rr_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Port-A arbiter for CPU (0) and DMA/display (1): one access per cycle, code-region writes suppressed.
// Grant is combinational in T; rvalid/rdata/err return in T+1, fully pipelined.
// A requester holds its request until gnt; losers wait without any queueing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_SIZE    = 16,
  parameter int ADDRESS_SIZE = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDRESS_SIZE-1:0] addr0,
  input  logic [ADDRESS_SIZE-1:0] addr1,
  input  logic [DATA_SIZE-1:0]    wdata0,
  input  logic [DATA_SIZE-1:0]    wdata1,
  input  logic                    lock0,
  input  logic                    lock1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [DATA_SIZE-1:0]    rdata0,
  output logic [DATA_SIZE-1:0]    rdata1,
  output logic                    err0,
  output logic                    err1,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic                    mem_we,
  output logic [DATA_SIZE-1:0]    mem_writeData,
  input  logic [DATA_SIZE-1:0]    ram_out,
  input  logic [DATA_SIZE-1:0]    io_out
);

  logic                    rr_last;
  owner_t                  lock_owner;
  pend_t                   pend;
  logic [1:0]              pick;
  logic [1:0]              gnt;
  logic                    any_gnt;
  logic                    sel1;
  owner_t                  w_owner;
  logic                    w_we;
  logic                    w_lock;
  logic [ADDRESS_SIZE-1:0] w_addr;
  logic [DATA_SIZE-1:0]    w_wdata;
  logic [1:0]              w_region;
  logic [ADDRESS_SIZE-1:0] addr_hold;
  logic [DATA_SIZE-1:0]    wdata_hold;
  logic [DATA_SIZE-1:0]    rdata0_hold;
  logic [DATA_SIZE-1:0]    rdata1_hold;
  logic [DATA_SIZE-1:0]    rsp_dat;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .rr_last    (rr_last),
    .lock_owner (lock_owner),
    .gnt        (pick)
  );

  always_comb begin
    gnt      = reset_n ? pick : 2'b00;
    any_gnt  = |gnt;
    sel1     = gnt[1];
    w_owner  = sel1 ? OWNER_1 : OWNER_0;
    w_we     = sel1 ? we1 : we0;
    w_lock   = sel1 ? lock1 : lock0;
    w_addr   = sel1 ? addr1 : addr0;
    w_wdata  = sel1 ? wdata1 : wdata0;
    w_region = region_of(32'(w_addr), ADDRESS_SIZE);
  end

  // Issue side: the bus parks on the last issued access when idle.
  always_comb begin
    gnt0          = gnt[0];
    gnt1          = gnt[1];
    mem_we        = any_gnt & w_we & (w_region != REGION_CODE);
    mem_address   = !reset_n ? '0 : (any_gnt ? w_addr : addr_hold);
    mem_writeData = !reset_n ? '0 : (any_gnt ? w_wdata : wdata_hold);
  end

  // Response side: a response still in flight when reset arrives is dropped.
  always_comb begin
    rsp_dat = (pend.region == REGION_IO) ? io_out : ram_out;
    rvalid0 = reset_n & pend.vld & (pend.owner == OWNER_0);
    rvalid1 = reset_n & pend.vld & (pend.owner == OWNER_1);
    err0    = rvalid0 & pend.perr;
    err1    = rvalid1 & pend.perr;
    rdata0  = rvalid0 ? rsp_dat : rdata0_hold;
    rdata1  = rvalid1 ? rsp_dat : rdata1_hold;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_last     <= 1'b1;
      lock_owner  <= OWNER_NONE;
      pend        <= '0;
      addr_hold   <= '0;
      wdata_hold  <= '0;
      rdata0_hold <= '0;
      rdata1_hold <= '0;
    end else begin
      pend.vld    <= any_gnt;
      pend.owner  <= w_owner;
      pend.region <= w_region;
      pend.perr   <= w_we & (w_region == REGION_CODE);
      lock_owner  <= (any_gnt && w_lock) ? w_owner : OWNER_NONE;
      if (any_gnt) begin
        rr_last    <= sel1;
        addr_hold  <= w_addr;
        wdata_hold <= w_wdata;
      end
      if (rvalid0) rdata0_hold <= rsp_dat;
      if (rvalid1) rdata1_hold <= rsp_dat;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter with a rule-level reference model and directed scenarios.
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int CODE_END = 1 << (AW - 2);
  localparam int IO_BASE  = 3 << (AW - 2);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_writeData;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] ram_out = '0;
  logic [DW-1:0] io_out = '0;

  mem_port_arbiter #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .mem_address(mem_address), .mem_we(mem_we),
    .mem_writeData(mem_writeData), .ram_out(ram_out), .io_out(io_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Requester intent, held until granted.
  bit            a_req[2], a_we[2], a_lock[2];
  logic [AW-1:0] a_addr[2];
  logic [DW-1:0] a_wd[2];

  // Reference model state: who went last, who holds the lock, the one outstanding response.
  int            m_rr_last, m_lock, m_pw;
  bit            m_pv, m_pio, m_perr;
  logic [DW-1:0] m_rd[2];
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wd;

  logic          cap_rvalid0, cap_rvalid1, cap_err0, cap_err1, cap_mem_we;
  logic [DW-1:0] cap_rdata0;

  task automatic apply();
    req0 = a_req[0]; we0 = a_we[0]; addr0 = a_addr[0]; wdata0 = a_wd[0]; lock0 = a_lock[0];
    req1 = a_req[1]; we1 = a_we[1]; addr1 = a_addr[1]; wdata1 = a_wd[1]; lock1 = a_lock[1];
  endtask

  task automatic model_reset();
    m_rr_last = 1; m_lock = -1; m_pv = 0; m_pw = 0; m_pio = 0; m_perr = 0;
    m_rd[0] = '0; m_rd[1] = '0; m_last_addr = '0; m_last_wd = '0;
  endtask

  task automatic rand_req(input int i);
    a_req[i]  = 1'b1;
    a_we[i]   = 1'($urandom_range(0, 1));
    a_addr[i] = AW'($urandom);
    a_wd[i]   = DW'($urandom);
    a_lock[i] = ($urandom_range(0, 3) == 0);
  endtask

  // One clock: apply intent, check issue and response at the negedge, advance the model.
  task automatic step(output int w);
    apply();
    @(negedge clk);
    w = -1;
    if (m_lock == 0 && a_req[0]) w = 0;
    else if (m_lock == 1 && a_req[1]) w = 1;
    else if (a_req[0] && a_req[1]) w = 1 - m_rr_last;
    else if (a_req[0]) w = 0;
    else if (a_req[1]) w = 1;

    check_eq("gnt0", gnt0, w == 0);
    check_eq("gnt1", gnt1, w == 1);
    if (w >= 0) begin
      check_eq("mem_address", mem_address, a_addr[w]);
      check_eq("mem_writeData", mem_writeData, a_wd[w]);
      check_eq("mem_we", mem_we, a_we[w] && (int'(a_addr[w]) >= CODE_END));
    end else begin
      check_eq("mem_we_idle", mem_we, 0);
      check_eq("mem_address_hold", mem_address, m_last_addr);
      check_eq("mem_writeData_hold", mem_writeData, m_last_wd);
    end

    if (m_pv) m_rd[m_pw] = m_pio ? io_out : ram_out;
    check_eq("rvalid0", rvalid0, m_pv && m_pw == 0);
    check_eq("rvalid1", rvalid1, m_pv && m_pw == 1);
    check_eq("rdata0", rdata0, m_rd[0]);
    check_eq("rdata1", rdata1, m_rd[1]);
    check_eq("err0", err0, m_pv && m_pw == 0 && m_perr);
    check_eq("err1", err1, m_pv && m_pw == 1 && m_perr);

    cap_rvalid0 = rvalid0; cap_rvalid1 = rvalid1; cap_err0 = err0; cap_err1 = err1;
    cap_rdata0 = rdata0; cap_mem_we = mem_we;

    if (w >= 0) begin
      m_pv = 1; m_pw = w;
      m_pio  = int'(a_addr[w]) >= IO_BASE;
      m_perr = a_we[w] && (int'(a_addr[w]) < CODE_END);
      m_rr_last = w;
      m_lock = a_lock[w] ? w : -1;
      m_last_addr = a_addr[w];
      m_last_wd = a_wd[w];
    end else begin
      m_pv = 0;
      m_lock = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    reset_n = 1'b0;
    apply();
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      check_eq("rst_gnt0", gnt0, 0);
      check_eq("rst_gnt1", gnt1, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_address", mem_address, 0);
      check_eq("rst_mem_writeData", mem_writeData, 0);
      check_eq("rst_rvalid0", rvalid0, 0);
      check_eq("rst_rvalid1", rvalid1, 0);
      @(posedge clk);
      #1;
    end
    check_eq("rst_rdata0", rdata0, 0);
    check_eq("rst_rdata1", rdata1, 0);
    check_eq("rst_err0", err0, 0);
    check_eq("rst_err1", err1, 0);
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < 2; i++) begin
      a_req[i] = 0; a_we[i] = 0; a_lock[i] = 0; a_addr[i] = '0; a_wd[i] = '0;
    end
    model_reset();
    do_reset(2);

    // First read after reset returns the RAM word to requester 0.
    a_req[0] = 1; a_addr[0] = 12'h400;
    step(w);
    check_eq("t1_winner", w, 0);
    a_req[0] = 0; ram_out = 16'hBEEF;
    step(w);
    check_eq("t1_rvalid0", cap_rvalid0, 1);
    check_eq("t1_rdata0", cap_rdata0, 16'hBEEF);
    check_eq("t1_err0", cap_err0, 0);
    check_eq("t1_rvalid1", cap_rvalid1, 0);

    // Continuous contention alternates; 0 went last so 1 leads.
    a_req[0] = 1; a_addr[0] = 12'h450; a_req[1] = 1; a_addr[1] = 12'h860;
    for (int k = 0; k < 4; k++) begin
      ram_out = DW'($urandom);
      step(w);
      check_eq("t2_alternate", w, (k % 2 == 0) ? 1 : 0);
    end

    // Write into the code region is suppressed and flagged.
    a_req[0] = 0; a_req[1] = 1; a_we[1] = 1; a_addr[1] = 12'h010; a_wd[1] = 16'h1234;
    step(w);
    check_eq("t3_winner", w, 1);
    check_eq("t3_mem_we", cap_mem_we, 0);
    a_req[1] = 0; a_we[1] = 0;
    step(w);
    check_eq("t3_err1", cap_err1, 1);
    check_eq("t3_rvalid1", cap_rvalid1, 1);

    // Locked burst of three from requester 0 while 1 waits.
    a_req[1] = 1; a_addr[1] = 12'h500;
    a_req[0] = 1; a_addr[0] = 12'h600; a_lock[0] = 1;
    step(w); check_eq("t4_burst1", w, 0);
    step(w); check_eq("t4_burst2", w, 0);
    a_lock[0] = 0;
    step(w); check_eq("t4_burst3", w, 0);
    step(w); check_eq("t4_release", w, 1);

    // IO region read returns io_out rather than ram_out.
    a_req[1] = 0; a_addr[0] = 12'hFFE;
    step(w);
    check_eq("t5_winner", w, 0);
    a_req[0] = 0; io_out = 16'h02A5; ram_out = 16'hDEAD;
    step(w);
    check_eq("t5_rdata0", cap_rdata0, 16'h02A5);

    // Reset right after a grant discards its response; requester 0 wins first afterwards.
    a_req[0] = 1; a_addr[0] = 12'h100;
    step(w);
    check_eq("t6_winner", w, 0);
    do_reset(2);
    a_req[0] = 1; a_req[1] = 1;
    step(w);
    check_eq("t6_first_after_reset", w, 0);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      ram_out = DW'($urandom);
      io_out  = DW'($urandom);
      for (int i = 0; i < 2; i++)
        if (!a_req[i] && $urandom_range(0, 2) != 0) rand_req(i);
      if ($urandom_range(0, 199) == 0) do_reset(1);
      step(w);
      if (w >= 0) begin
        a_req[w] = ($urandom_range(0, 3) != 0);
        if (a_req[w]) rand_req(w);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
